hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller.sv | 130 +++++++++++++
 tb/tb_hazard_controller.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stalls, branch flush bubbles and
// data-memory wait stalls, plus a saturating stall-cycle counter.
module hazard_controller #(
  parameter int FLUSH_CYCLES      = 2,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       i_id_rs1_index,
  input  logic [4:0]       i_id_rs2_index,
  input  logic             i_id_uses_rs2,
  input  logic [4:0]       i_ex_rd_index,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_branch_taken,
  input  logic             i_dmem_busy,
  input  logic             i_cnt_clr,
  output logic             o_pc_stall,
  output logic             o_id_stall,
  output logic             o_ex_stall,
  output logic             o_id_bubble,
  output logic             o_flush_if_id,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stall_count
);

  typedef enum logic [1:0] {RUN = 2'd0, LOAD_USE = 2'd1, FLUSH = 2'd2, MEM_WAIT = 2'd3} state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] LOAD_INIT  = 3'(LOAD_STALL_CYCLES - 1);

  state_t     state;
  logic [2:0] cnt, sv;
  logic       hz, mem_stall, ld_stall, bubble, flush;

  assign hz = i_ex_mem_read && (i_ex_rd_index != 5'd0) &&
              ((i_ex_rd_index == i_id_rs1_index) ||
               (i_id_uses_rs2 && (i_ex_rd_index == i_id_rs2_index)));

  always_comb begin
    mem_stall = 1'b0;
    ld_stall  = 1'b0;
    bubble    = 1'b0;
    flush     = 1'b0;
    case (state)
      RUN: begin
        if (i_dmem_busy) mem_stall = 1'b1;
        else if (i_ex_branch_taken) begin
          flush  = 1'b1;
          bubble = 1'b1;
        end else if (hz) begin
          ld_stall = 1'b1;
          bubble   = 1'b1;
        end
      end
      LOAD_USE: begin
        ld_stall = 1'b1;
        bubble   = 1'b1;
      end
      FLUSH: begin
        if (i_dmem_busy) mem_stall = 1'b1;
        else begin
          flush  = 1'b1;
          bubble = 1'b1;
        end
      end
      MEM_WAIT: mem_stall = i_dmem_busy;
      default: ;
    endcase
  end

  // Outputs are forced low for the whole reset window, not just after an edge.
  assign o_pc_stall    = i_rst_n & (mem_stall | ld_stall);
  assign o_id_stall    = i_rst_n & (mem_stall | ld_stall);
  assign o_ex_stall    = i_rst_n & mem_stall;
  assign o_id_bubble   = i_rst_n & bubble;
  assign o_flush_if_id = i_rst_n & flush;
  assign o_state       = state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= RUN;
      cnt   <= 3'd0;
      sv    <= 3'd0;
    end else begin
      case (state)
        RUN: begin
          if (i_dmem_busy) begin
            state <= MEM_WAIT;
            sv    <= 3'd0;
          end else if (i_ex_branch_taken) begin
            cnt   <= FLUSH_INIT;
            state <= (FLUSH_INIT != 3'd0) ? FLUSH : RUN;
          end else if (hz) begin
            cnt   <= LOAD_INIT;
            state <= (LOAD_INIT != 3'd0) ? LOAD_USE : RUN;
          end
        end
        LOAD_USE: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= RUN;
        end
        FLUSH: begin
          if (i_dmem_busy) begin
            // Remember how much of the flush is left to resume after the wait.
            sv    <= cnt;
            state <= MEM_WAIT;
          end else begin
            cnt <= cnt - 3'd1;
            if (cnt == 3'd1) state <= RUN;
          end
        end
        MEM_WAIT: begin
          if (!i_dmem_busy) begin
            cnt   <= sv;
            state <= (sv != 3'd0) ? FLUSH : RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                            o_stall_count <= '0;
    else if (i_cnt_clr)                      o_stall_count <= '0;
    else if (o_pc_stall && o_stall_count != '1) o_stall_count <= o_stall_count + 1'b1;
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench: the driver predicts each cycle's response from a
// pending-work model and queues it; the monitor compares what the DUT shows.
module tb_hazard_controller;
  localparam int FC  = 2;
  localparam int LSC = 2;
  localparam int CW  = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [4:0]    rs1 = '0, rs2 = '0, rd = '0;
  logic          u2 = 1'b0, mr = 1'b0, br = 1'b0, busy = 1'b0, clr = 1'b0;
  logic          pc_s, id_s, ex_s, bub, fl;
  logic [1:0]    st;
  logic [CW-1:0] scnt;

  hazard_controller #(.FLUSH_CYCLES(FC), .LOAD_STALL_CYCLES(LSC), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_rs1_index(rs1), .i_id_rs2_index(rs2),
    .i_id_uses_rs2(u2), .i_ex_rd_index(rd), .i_ex_mem_read(mr),
    .i_ex_branch_taken(br), .i_dmem_busy(busy), .i_cnt_clr(clr),
    .o_pc_stall(pc_s), .o_id_stall(id_s), .o_ex_stall(ex_s), .o_id_bubble(bub),
    .o_flush_if_id(fl), .o_state(st), .o_stall_count(scnt));

  always #5 clk = ~clk;

  typedef struct packed {
    logic pc, id, ex, bub, fl;
    logic [1:0] st;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  bit   done = 0;

  // Model: what is pending (flush bubbles, load stalls, a memory wait and the
  // flush slots it interrupted) rather than a register-level copy.
  int mode = 0, flush_left = 0, load_left = 0, paused_flush = 0, stalls = 0;

  function automatic bit hazard();
    if (!mr || rd == 0) return 0;
    return (rd == rs1) || (u2 && rd == rs2);
  endfunction

  task automatic model_step(output exp_t e);
    bit stall_mem, stall_ld, do_flush;
    e = '0;
    if (!rst_n) begin
      mode = 0; flush_left = 0; load_left = 0; paused_flush = 0; stalls = 0;
      return;
    end
    e.st = 2'(mode);
    e.cnt = CW'(stalls);
    stall_mem = 0; stall_ld = 0; do_flush = 0;
    if (mode == 0) begin
      if (busy) begin stall_mem = 1; paused_flush = 0; mode = 3; end
      else if (br) begin do_flush = 1; flush_left = FC - 1; mode = (flush_left > 0) ? 2 : 0; end
      else if (hazard()) begin stall_ld = 1; load_left = LSC - 1; mode = (load_left > 0) ? 1 : 0; end
    end else if (mode == 1) begin
      stall_ld = 1; load_left--; if (load_left == 0) mode = 0;
    end else if (mode == 2) begin
      if (busy) begin stall_mem = 1; paused_flush = flush_left; mode = 3; end
      else begin do_flush = 1; flush_left--; if (flush_left == 0) mode = 0; end
    end else begin
      if (busy) stall_mem = 1;
      else if (paused_flush > 0) begin flush_left = paused_flush; mode = 2; end
      else mode = 0;
    end
    e.pc  = stall_mem | stall_ld;
    e.id  = stall_mem | stall_ld;
    e.ex  = stall_mem;
    e.bub = stall_ld | do_flush;
    e.fl  = do_flush;
    if (clr) stalls = 0;
    else if (e.pc && stalls < (1 << CW) - 1) stalls++;
  endtask

  task automatic cyc(input logic r, input logic b, input logic t, input logic m,
                     input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                     input logic uu, input logic c);
    exp_t e;
    @(negedge clk);
    rst_n = r; busy = b; br = t; mr = m; rd = d; rs1 = s1; rs2 = s2; u2 = uu; clr = c;
    #1;
    model_step(e);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e, a;
    while (!done) begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = {pc_s, id_s, ex_s, bub, fl, st, scnt};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle_outputs t=%0t got pc/id/ex/bub/fl=%b%b%b%b%b st=%0d cnt=%0d expected %b%b%b%b%b st=%0d cnt=%0d",
                   $time, a.pc, a.id, a.ex, a.bub, a.fl, a.st, a.cnt,
                   e.pc, e.id, e.ex, e.bub, e.fl, e.st, e.cnt);
        end
      end
    end
  end

  initial begin : driver
    // reset with noisy inputs: outputs must stay low
    cyc(0, 1, 1, 1, 5, 5, 5, 1, 0);
    cyc(0, 0, 1, 1, 3, 3, 0, 0, 0);
    idle(1);
    // load x5 with rs1=5
    cyc(1, 0, 0, 1, 5, 5, 0, 0, 0);
    idle(LSC + 1);
    // x0 never hazards; rs2 match ignored when rs2 unused
    cyc(1, 0, 0, 1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 7, 1, 7, 0, 0);
    cyc(1, 0, 0, 1, 7, 1, 7, 1, 0);
    idle(LSC + 1);
    // branch flush
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(3);
    // branch, then memory busy across the second flush slot
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 2, 2, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    // everything at once in RUN; clear while stalling
    cyc(1, 1, 1, 1, 4, 4, 4, 1, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    // reset pulse mid-flush
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // randomized traffic; small index range to make hazards frequent
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 5) == 0), $urandom_range(0, 1),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          $urandom_range(0, 1), ($urandom_range(0, 39) == 0));
    end
    idle(2);
    @(negedge clk);
    #3;
    done = 1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
